alu_share_ctrl: RTL and testbench

- Multi-cycle scheduler that shares one 4-bit combinational ALU between two requesters (client 0, client 1).
- ALU opcodes: 00 add, 01 sub, 10 nand, 11 xor. ALU error = signed overflow on add/sub; always 0 on nand/xor.
- The controller arbitrates round-robin, registers the winner's operands onto the ALU inputs, and captures the ALU result and error.
- It returns the result with a requester tag and keeps a saturating overflow count. The ALU sits outside this block, wired to the alu_* ports.

---
 rtl/alu_share_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one external 4-bit combinational ALU between two requesters. The
// block picks a winner round-robin, registers that winner's operands onto the
// ALU inputs, captures the ALU result one cycle later and returns it tagged
// with the owning client. It also counts responses that carried an overflow,
// saturating at all-ones.
//
// Each operation takes three cycles (grant, execute, respond) and only one
// operation is in flight at a time.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req0/op0/a0/b0      client 0 request, opcode and operands
//   gnt0                client 0 operands captured (one-cycle pulse)
//   req1/op1/a1/b1      client 1 request, opcode and operands
//   gnt1                client 1 operands captured (one-cycle pulse)
//   alu_in1/alu_in2     registered ALU operands
//   alu_op              registered ALU opcode (00 add, 01 sub, 10 nand, 11 xor)
//   alu_out/alu_err     result and overflow flag from the external ALU
//   rsp_valid           one-cycle pulse: rsp_id/rsp_data/rsp_err valid
//   rsp_id              client owning the response
//   rsp_data/rsp_err    captured ALU result and overflow flag
//   busy                high while an operation is in flight
//   ovfl_cnt            saturating count of responses with rsp_err set
//
// State table
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for a request; arbitration happens on the exit edge
//   EXEC    | operands on ALU inputs, grant pulse high, result captured
//   RESP    | response pulse high, overflow count updated on the exit edge
// ---------------------------------------------------------------------------
module alu_share_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0,
   input  logic [1:0]       op0,
   input  logic [3:0]       a0,
   input  logic [3:0]       b0,
   output logic             gnt0,

   input  logic             req1,
   input  logic [1:0]       op1,
   input  logic [3:0]       a1,
   input  logic [3:0]       b1,
   output logic             gnt1,

   output logic [3:0]       alu_in1,
   output logic [3:0]       alu_in2,
   output logic [1:0]       alu_op,
   input  logic [3:0]       alu_out,
   input  logic             alu_err,

   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [3:0]       rsp_data,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] ovfl_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q,     state_d;
   logic             last_q,      last_d;
   logic             gnt0_q,      gnt0_d;
   logic             gnt1_q,      gnt1_d;
   logic [3:0]       alu_in1_q,   alu_in1_d;
   logic [3:0]       alu_in2_q,   alu_in2_d;
   logic [1:0]       alu_op_q,    alu_op_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q,    rsp_id_d;
   logic [3:0]       rsp_data_q,  rsp_data_d;
   logic             rsp_err_q,   rsp_err_d;
   logic [CNT_W-1:0] ovfl_cnt_q,  ovfl_cnt_d;

   logic             win_vld;
   logic             win_id;

   // Round-robin pick. On a tie the client that did not win last time goes.
   always_comb begin
      win_vld = req0 | req1;
      win_id  = 1'b0;
      if (req0 && req1) begin
         win_id = ~last_q;
      end else if (req1) begin
         win_id = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      alu_in1_d   = alu_in1_q;
      alu_in2_d   = alu_in2_q;
      alu_op_d    = alu_op_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      ovfl_cnt_d  = ovfl_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               if (win_id) begin
                  alu_in1_d = a1;
                  alu_in2_d = b1;
                  alu_op_d  = op1;
                  gnt1_d    = 1'b1;
               end else begin
                  alu_in1_d = a0;
                  alu_in2_d = b0;
                  alu_op_d  = op0;
                  gnt0_d    = 1'b1;
               end
               last_d   = win_id;
               rsp_id_d = win_id;
               state_d  = ST_EXEC;
            end
         end

         ST_EXEC: begin
            rsp_data_d  = alu_out;
            rsp_err_d   = alu_err;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end

         ST_RESP: begin
            if (rsp_err_q && (ovfl_cnt_q != CNT_MAX)) begin
               ovfl_cnt_d = ovfl_cnt_q + CNT_ONE;
            end
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         alu_in1_q   <= 4'd0;
         alu_in2_q   <= 4'd0;
         alu_op_q    <= 2'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= 4'd0;
         rsp_err_q   <= 1'b0;
         ovfl_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         alu_in1_q   <= alu_in1_d;
         alu_in2_q   <= alu_in2_d;
         alu_op_q    <= alu_op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         ovfl_cnt_q  <= ovfl_cnt_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign alu_in1   = alu_in1_q;
   assign alu_in2   = alu_in2_q;
   assign alu_op    = alu_op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != ST_IDLE);
   assign ovfl_cnt  = ovfl_cnt_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
//
// Bench for alu_share_ctrl. Provides the shared 4-bit ALU as a small
// combinational model on the alu_* ports, then applies a table of single
// operations followed by hand-written multi-cycle sequences: round-robin
// with both clients held, overflow counter saturation, reset during EXEC,
// and a request raised during RESP.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;

   localparam int CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             req0, req1;
   logic [1:0]       op0, op1;
   logic [3:0]       a0, b0, a1, b1;
   logic             gnt0, gnt1;
   logic [3:0]       alu_in1, alu_in2;
   logic [1:0]       alu_op;
   logic [3:0]       alu_out;
   logic             alu_err;
   logic             rsp_valid, rsp_id, rsp_err, busy;
   logic [3:0]       rsp_data;
   logic [CNT_W-1:0] ovfl_cnt;

   int n_chk = 0;
   int n_err = 0;
   int exp_cnt = 0;

   alu_share_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .op0       (op0),
      .a0        (a0),
      .b0        (b0),
      .gnt0      (gnt0),
      .req1      (req1),
      .op1       (op1),
      .a1        (a1),
      .b1        (b1),
      .gnt1      (gnt1),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_op    (alu_op),
      .alu_out   (alu_out),
      .alu_err   (alu_err),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .ovfl_cnt  (ovfl_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU: signed overflow flag on add/sub only.
   always_comb begin
      alu_out = 4'd0;
      alu_err = 1'b0;
      case (alu_op)
         2'b00: begin
            alu_out = alu_in1 + alu_in2;
            alu_err = (alu_in1[3] == alu_in2[3]) && (alu_out[3] != alu_in1[3]);
         end
         2'b01: begin
            alu_out = alu_in1 - alu_in2;
            alu_err = (alu_in1[3] != alu_in2[3]) && (alu_out[3] != alu_in1[3]);
         end
         2'b10:   alu_out = ~(alu_in1 & alu_in2);
         default: alu_out = alu_in1 ^ alu_in2;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " gnt0"},      32'(gnt0),      32'd0);
      chk({tag, " gnt1"},      32'(gnt1),      32'd0);
      chk({tag, " alu_in1"},   32'(alu_in1),   32'd0);
      chk({tag, " alu_in2"},   32'(alu_in2),   32'd0);
      chk({tag, " alu_op"},    32'(alu_op),    32'd0);
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, " rsp_id"},    32'(rsp_id),    32'd0);
      chk({tag, " rsp_data"},  32'(rsp_data),  32'd0);
      chk({tag, " rsp_err"},   32'(rsp_err),   32'd0);
      chk({tag, " busy"},      32'(busy),      32'd0);
      chk({tag, " ovfl_cnt"},  32'(ovfl_cnt),  32'd0);
   endtask

   // One operation from a single client, entered at a negedge in IDLE.
   // Grant is expected on the very next cycle, response the cycle after.
   task automatic run_op(input bit c, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] ed, input bit ee);
      if (c) begin
         req1 = 1'b1; op1 = op; a1 = a; b1 = b;
      end else begin
         req0 = 1'b1; op0 = op; a0 = a; b0 = b;
      end
      @(negedge clk);
      chk("op gnt0",    32'(gnt0),    32'(!c));
      chk("op gnt1",    32'(gnt1),    32'(c));
      chk("op alu_in1", 32'(alu_in1), 32'(a));
      chk("op alu_in2", 32'(alu_in2), 32'(b));
      chk("op alu_op",  32'(alu_op),  32'(op));
      chk("op busy",    32'(busy),    32'd1);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      chk("op rsp_valid", 32'(rsp_valid), 32'd1);
      chk("op rsp_id",    32'(rsp_id),    32'(c));
      chk("op rsp_data",  32'(rsp_data),  32'(ed));
      chk("op rsp_err",   32'(rsp_err),   32'(ee));
      chk("op gnt off",   32'(gnt0 | gnt1), 32'd0);
      if (ee && exp_cnt != 255) exp_cnt++;
      @(negedge clk);
      chk("op idle rsp_valid", 32'(rsp_valid), 32'd0);
      chk("op idle busy",      32'(busy),      32'd0);
      chk("op idle rsp_data",  32'(rsp_data),  32'(ed));
      chk("op ovfl_cnt",       32'(ovfl_cnt),  32'(exp_cnt));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst");
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit         c;
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] d;
      bit         e;
   } vec_t;

   vec_t vt[10];

   initial begin
      vt[0] = '{c: 1'b0, op: 2'b00, a: 4'b0011, b: 4'b0100, d: 4'b0111, e: 1'b0};
      vt[1] = '{c: 1'b1, op: 2'b00, a: 4'b0111, b: 4'b0001, d: 4'b1000, e: 1'b1};
      vt[2] = '{c: 1'b0, op: 2'b10, a: 4'b1111, b: 4'b1111, d: 4'b0000, e: 1'b0};
      vt[3] = '{c: 1'b1, op: 2'b01, a: 4'b0101, b: 4'b0010, d: 4'b0011, e: 1'b0};
      vt[4] = '{c: 1'b0, op: 2'b11, a: 4'b1100, b: 4'b1010, d: 4'b0110, e: 1'b0};
      vt[5] = '{c: 1'b0, op: 2'b01, a: 4'b1000, b: 4'b0001, d: 4'b0111, e: 1'b1};
      vt[6] = '{c: 1'b1, op: 2'b00, a: 4'b1000, b: 4'b1000, d: 4'b0000, e: 1'b1};
      vt[7] = '{c: 1'b1, op: 2'b01, a: 4'b0011, b: 4'b0101, d: 4'b1110, e: 1'b0};
      vt[8] = '{c: 1'b0, op: 2'b10, a: 4'b1100, b: 4'b1010, d: 4'b0111, e: 1'b0};
      vt[9] = '{c: 1'b1, op: 2'b11, a: 4'b1111, b: 4'b0001, d: 4'b1110, e: 1'b0};

      rst_n = 1'b0;
      req0 = 1'b0; op0 = 2'd0; a0 = 4'd0; b0 = 4'd0;
      req1 = 1'b0; op1 = 2'd0; a1 = 4'd0; b1 = 4'd0;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("init");
      rst_n = 1'b1;

      // Table of single operations.
      for (int i = 0; i < 10; i++) begin
         run_op(vt[i].c, vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].e);
      end

      // Both clients held: grants alternate 0,1,0,1 every third cycle.
      do_reset();
      req0 = 1'b1; op0 = 2'b01; a0 = 4'b0101; b0 = 4'b0010;
      req1 = 1'b1; op1 = 2'b11; a1 = 4'b1100; b1 = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rr gnt0",    32'(gnt0),    32'((k % 2) == 0));
         chk("rr gnt1",    32'(gnt1),    32'((k % 2) == 1));
         chk("rr alu_in1", 32'(alu_in1), ((k % 2) == 0) ? 32'h5 : 32'hc);
         chk("rr busy",    32'(busy),    32'd1);
         @(negedge clk);
         chk("rr rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rr rsp_id",    32'(rsp_id),    32'(k % 2));
         chk("rr rsp_data",  32'(rsp_data),  ((k % 2) == 0) ? 32'h3 : 32'h6);
         chk("rr resp busy", 32'(busy),      32'd1);
         if (k == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         @(negedge clk);
         chk("rr idle gnt", 32'(gnt0 | gnt1 | rsp_valid), 32'd0);
      end
      @(negedge clk);
      chk("rr no grant after drop", 32'(gnt0 | gnt1 | busy), 32'd0);

      // Overflow counter saturation.
      for (int n = 0; n < 260; n++) begin
         run_op(1'b1, 2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b1);
      end
      chk("sat ovfl_cnt", 32'(ovfl_cnt), 32'd255);

      // nand does not touch the counter.
      run_op(1'b0, 2'b10, 4'b1111, 4'b1111, 4'b0000, 1'b0);
      chk("nand keeps cnt", 32'(ovfl_cnt), 32'd255);

      // Reset asserted asynchronously during EXEC.
      req0 = 1'b1; op0 = 2'b00; a0 = 4'b0001; b0 = 4'b0001;
      @(negedge clk);
      chk("mid gnt0", 32'(gnt0), 32'd1);
      chk("mid busy", 32'(busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("mid rst");
      exp_cnt = 0;
      @(negedge clk);
      chk("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post rst gnt0",      32'(gnt0),      32'd1);
      chk("post rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post rst alu_in1",   32'(alu_in1),   32'd1);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      @(negedge clk);
      chk("post rst rsp_valid2", 32'(rsp_valid), 32'd1);
      chk("post rst rsp_data",   32'(rsp_data),  32'd2);
      @(negedge clk);
      chk("post rst ovfl_cnt",   32'(ovfl_cnt),  32'd0);

      // req1 raised during RESP of a client 0 op; req0 raised in the IDLE cycle.
      req0 = 1'b1; op0 = 2'b00; a0 = 4'b0010; b0 = 4'b0011;
      @(negedge clk);
      chk("late gnt0", 32'(gnt0), 32'd1);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b1; op1 = 2'b11; a1 = 4'b1111; b1 = 4'b0101;
      @(negedge clk);
      chk("late rsp_valid", 32'(rsp_valid), 32'd1);
      chk("late rsp_data",  32'(rsp_data),  32'd5);
      chk("late rsp gnt1",  32'(gnt1),      32'd0);
      @(posedge clk);
      #1;
      req0 = 1'b1; op0 = 2'b01; a0 = 4'b0111; b0 = 4'b0011;
      @(negedge clk);
      chk("late idle gnt", 32'(gnt0 | gnt1), 32'd0);
      chk("late idle busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("late gnt1",    32'(gnt1),    32'd1);
      chk("late gnt0 lose", 32'(gnt0),  32'd0);
      chk("late alu_in1", 32'(alu_in1), 32'hf);
      @(posedge clk);
      #1;
      req1 = 1'b0;
      @(negedge clk);
      chk("late rsp_id1",   32'(rsp_id),   32'd1);
      chk("late rsp_data1", 32'(rsp_data), 32'ha);
      @(negedge clk);
      chk("late idle2 gnt0", 32'(gnt0), 32'd0);
      @(negedge clk);
      chk("late gnt0 next", 32'(gnt0), 32'd1);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      @(negedge clk);
      chk("late rsp_id0",   32'(rsp_id),   32'd0);
      chk("late rsp_data0", 32'(rsp_data), 32'h4);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
